// File: rtl/smvm_stream_tx.sv
// smvm_stream_tx: buffers one SMVM job (header, dense vector, nonzero entries) and then
// replays it as a single gap-free stream on the val/col/ipv lanes for the SMVM core.
//
// Handshake rule for both input channels (vec_*, nz_*): a transfer happens on the rising
// clk edge where valid and ready are both 1. The ready signals depend only on registered
// state. The sender may hold valid low between transfers.
//
// The stream lanes, done and the state register are updated on the same edge. For that
// reason state_q always names the stream word currently visible on the lanes.
module smvm_stream_tx #(
  parameter int DATA_W   = 8,
  parameter int COL_W    = 3,
  parameter int MAX_COLS = 128,
  parameter int NZ_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] rows_in,
  input  logic [DATA_W-1:0] cols_in,
  input  logic              vec_valid,
  input  logic [DATA_W-1:0] vec_data,
  output logic              vec_ready,
  input  logic              nz_valid,
  input  logic [DATA_W-1:0] nz_val,
  input  logic [COL_W-1:0]  nz_col,
  input  logic              nz_ipv,
  input  logic              nz_last,
  output logic              nz_ready,
  output logic [DATA_W-1:0] val_out,
  output logic [COL_W-1:0]  col_out,
  output logic              ipv_out,
  output logic              busy,
  output logic              done,
  output logic              err_zero,
  output logic              err_ovf,
  output logic [2:0]        dbg_state
);

  localparam int VA_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int NA_W = (NZ_DEPTH > 1) ? $clog2(NZ_DEPTH) : 1;
  localparam int NC_W = $clog2(NZ_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TX_ROWS, S_TX_COLS, S_TX_VEC, S_TX_VAL, S_TX_IDX, S_TX_END
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] rows_q, cols_q, vec_cnt_q, tx_idx_q;
  logic [NC_W-1:0]   nz_cnt_q, rd_q;
  logic              load_done_q;
  logic [DATA_W-1:0] val_q;
  logic [COL_W-1:0]  col_q;
  logic              ipv_q, done_q, err_zero_q, err_ovf_q;

  logic [DATA_W-1:0] vec_mem [MAX_COLS];
  logic [DATA_W-1:0] nzv_mem [NZ_DEPTH];
  logic [COL_W-1:0]  nzc_mem [NZ_DEPTH];
  logic              nzi_mem [NZ_DEPTH];

  logic start_ok, vec_fire, nz_fire, nz_keep, have_entry;

  assign start_ok   = start && (rows_in != '0) && (cols_in != '0) && (int'(cols_in) <= MAX_COLS);
  assign vec_ready  = (state_q == S_LOAD) && (vec_cnt_q != cols_q);
  assign nz_ready   = (state_q == S_LOAD) && !load_done_q && (int'(nz_cnt_q) < NZ_DEPTH);
  assign vec_fire   = vec_valid && vec_ready;
  assign nz_fire    = nz_valid && nz_ready;
  assign nz_keep    = nz_fire && (nz_val != '0);
  assign have_entry = (rd_q != nz_cnt_q);

  assign val_out   = val_q;
  assign col_out   = col_q;
  assign ipv_out   = ipv_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign err_zero  = err_zero_q;
  assign err_ovf   = err_ovf_q;
  assign dbg_state = state_q;

  // Job storage: vector elements and non-zero entries, written during LOAD only.
  always_ff @(posedge clk) begin
    if (vec_fire) vec_mem[vec_cnt_q[VA_W-1:0]] <= vec_data;
    if (nz_keep) begin
      nzv_mem[nz_cnt_q[NA_W-1:0]] <= nz_val;
      nzc_mem[nz_cnt_q[NA_W-1:0]] <= nz_col;
      nzi_mem[nz_cnt_q[NA_W-1:0]] <= nz_ipv;
    end
  end

  // Job FSM: load bookkeeping, then one stream word per cycle on the registered lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      vec_cnt_q   <= '0;
      tx_idx_q    <= '0;
      nz_cnt_q    <= '0;
      rd_q        <= '0;
      load_done_q <= 1'b0;
      val_q       <= '0;
      col_q       <= '0;
      ipv_q       <= 1'b0;
      done_q      <= 1'b0;
      err_zero_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      val_q  <= '0;
      col_q  <= '0;
      ipv_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            rows_q      <= rows_in;
            cols_q      <= cols_in;
            vec_cnt_q   <= '0;
            nz_cnt_q    <= '0;
            rd_q        <= '0;
            load_done_q <= 1'b0;
            err_zero_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (vec_fire) vec_cnt_q <= vec_cnt_q + 1'b1;
          if (nz_fire) begin
            if (nz_val == '0) err_zero_q <= 1'b1;
            else              nz_cnt_q   <= nz_cnt_q + 1'b1;
            // A zero entry still carries a valid last flag; a full FIFO without last ends the load.
            if (nz_last) begin
              load_done_q <= 1'b1;
            end else if (nz_keep && (nz_cnt_q == NC_W'(NZ_DEPTH - 1))) begin
              err_ovf_q   <= 1'b1;
              load_done_q <= 1'b1;
            end
          end
          if ((vec_cnt_q == cols_q) && load_done_q) begin
            state_q <= S_TX_ROWS;
            val_q   <= rows_q;
          end
        end
        S_TX_ROWS: begin
          state_q <= S_TX_COLS;
          val_q   <= cols_q;
        end
        S_TX_COLS: begin
          state_q  <= S_TX_VEC;
          val_q    <= vec_mem[0];
          tx_idx_q <= {{(DATA_W-1){1'b0}}, 1'b1};
        end
        S_TX_VEC, S_TX_IDX: begin
          if ((state_q == S_TX_VEC) && (tx_idx_q != cols_q)) begin
            val_q    <= vec_mem[tx_idx_q[VA_W-1:0]];
            tx_idx_q <= tx_idx_q + 1'b1;
          end else if (have_entry) begin
            state_q <= S_TX_VAL;
            val_q   <= nzv_mem[rd_q[NA_W-1:0]];
            ipv_q   <= nzi_mem[rd_q[NA_W-1:0]];
          end else begin
            state_q <= S_TX_END;
            done_q  <= 1'b1;
          end
        end
        S_TX_VAL: begin
          state_q <= S_TX_IDX;
          col_q   <= nzc_mem[rd_q[NA_W-1:0]];
          rd_q    <= rd_q + 1'b1;
        end
        S_TX_END: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smvm_stream_tx.sv
// Bench for smvm_stream_tx: directed jobs from the block description plus randomized jobs.
// Expected streams come from a job-level model: drop zero entries, cut at last or at a full
// FIFO, then emit rows, cols, vector, (val,col) pairs and a terminator.
module tb_smvm_stream_tx;
  localparam int DATA_W   = 8;
  localparam int COL_W    = 3;
  localparam int MAX_COLS = 128;
  localparam int NZ_DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] rows_in = '0, cols_in = '0;
  logic              vec_valid = 1'b0;
  logic [DATA_W-1:0] vec_data = '0;
  logic              vec_ready;
  logic              nz_valid = 1'b0;
  logic [DATA_W-1:0] nz_val = '0;
  logic [COL_W-1:0]  nz_col = '0;
  logic              nz_ipv = 1'b0, nz_last = 1'b0;
  logic              nz_ready;
  logic [DATA_W-1:0] val_out;
  logic [COL_W-1:0]  col_out;
  logic              ipv_out, busy, done, err_zero, err_ovf;
  logic [2:0]        dbg_state;

  smvm_stream_tx #(.DATA_W(DATA_W), .COL_W(COL_W), .MAX_COLS(MAX_COLS), .NZ_DEPTH(NZ_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rows_in(rows_in), .cols_in(cols_in),
    .vec_valid(vec_valid), .vec_data(vec_data), .vec_ready(vec_ready),
    .nz_valid(nz_valid), .nz_val(nz_val), .nz_col(nz_col), .nz_ipv(nz_ipv), .nz_last(nz_last),
    .nz_ready(nz_ready), .val_out(val_out), .col_out(col_out), .ipv_out(ipv_out),
    .busy(busy), .done(done), .err_zero(err_zero), .err_ovf(err_ovf), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Current job
  logic [7:0] j_vec  [0:MAX_COLS-1];
  logic [7:0] j_val  [0:63];
  logic [2:0] j_col  [0:63];
  logic       j_ipv  [0:63];
  logic       j_last [0:63];
  int         j_n;

  // Model results: stream words packed as {done, ipv, col, val}
  logic [12:0] exp_q[$];
  int          m_acc;
  bit          m_ez, m_eo;
  bit          aborted;

  task automatic build_model(input logic [7:0] r, input logic [7:0] c);
    logic [7:0] sv[$];
    logic [2:0] sc[$];
    logic       si[$];
    exp_q.delete();
    m_acc = 0; m_ez = 0; m_eo = 0;
    for (int i = 0; i < j_n; i++) begin
      m_acc++;
      if (j_val[i] == 8'd0) m_ez = 1;
      else begin sv.push_back(j_val[i]); sc.push_back(j_col[i]); si.push_back(j_ipv[i]); end
      if (j_last[i]) break;
      if (sv.size() == NZ_DEPTH) begin m_eo = 1; break; end
    end
    exp_q.push_back({1'b0, 1'b0, 3'd0, r});
    exp_q.push_back({1'b0, 1'b0, 3'd0, c});
    for (int i = 0; i < int'(c); i++) exp_q.push_back({1'b0, 1'b0, 3'd0, j_vec[i]});
    for (int k = 0; k < sv.size(); k++) begin
      exp_q.push_back({1'b0, si[k], 3'd0, sv[k]});
      exp_q.push_back({1'b0, 1'b0, sc[k], 8'd0});
    end
    exp_q.push_back({1'b1, 1'b0, 3'd0, 8'd0});
  endtask

  task automatic gen_job(input int c, input int n, input int zero_pct, input bit with_last);
    for (int i = 0; i < c; i++) j_vec[i] = 8'($urandom_range(0, 255));
    j_n = n;
    for (int i = 0; i < n; i++) begin
      j_val[i]  = ($urandom_range(0, 99) < zero_pct) ? 8'd0 : 8'($urandom_range(1, 255));
      j_col[i]  = 3'($urandom_range(0, 7));
      j_ipv[i]  = 1'($urandom_range(0, 1));
      j_last[i] = with_last && (i == n - 1);
    end
  endtask

  task automatic set_t1();
    j_vec[0] = 8'd5; j_vec[1] = 8'hFF; j_vec[2] = 8'd7;
    j_n = 2;
    j_val[0] = 8'd3; j_col[0] = 3'd0; j_ipv[0] = 1'b1; j_last[0] = 1'b0;
    j_val[1] = 8'd4; j_col[1] = 3'd2; j_ipv[1] = 1'b0; j_last[1] = 1'b1;
  endtask

  task automatic set_t3();
    j_vec[0] = 8'd9; j_vec[1] = 8'd1; j_vec[2] = 8'h80;
    j_n = 3;
    j_val[0] = 8'd6; j_col[0] = 3'd1; j_ipv[0] = 1'b1; j_last[0] = 1'b0;
    j_val[1] = 8'd0; j_col[1] = 3'd3; j_ipv[1] = 1'b1; j_last[1] = 1'b0;
    j_val[2] = 8'd2; j_col[2] = 3'd4; j_ipv[2] = 1'b1; j_last[2] = 1'b1;
  endtask

  // Drivers: called at posedge+1, sample ready at negedge, transfer at the next posedge.
  task automatic do_start(input logic [7:0] r, input logic [7:0] c);
    start = 1'b1; rows_in = r; cols_in = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_vec(input int n, input int delay, input int gap);
    repeat (delay) begin @(posedge clk); #1; end
    for (int i = 0; i < n; i++) begin
      int  g;
      int  guard;
      bit  acc;
      g = (gap > 0) ? $urandom_range(0, gap) : 0;
      repeat (g) begin @(posedge clk); #1; end
      vec_valid = 1'b1; vec_data = j_vec[i];
      acc = 0; guard = 0;
      while (!acc && guard < 2000) begin
        @(negedge clk); acc = vec_ready; @(posedge clk); #1; guard++;
      end
      vec_valid = 1'b0;
      check_eq("vec_handshake", 32'(acc), 32'd1);
      if (!acc) break;
    end
  endtask

  task automatic drive_nz(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int  g;
      int  guard;
      bit  acc;
      g = (gap > 0) ? $urandom_range(0, gap) : 0;
      repeat (g) begin @(posedge clk); #1; end
      nz_valid = 1'b1; nz_val = j_val[i]; nz_col = j_col[i]; nz_ipv = j_ipv[i]; nz_last = j_last[i];
      acc = 0; guard = 0;
      while (!acc && guard < 2000) begin
        @(negedge clk); acc = nz_ready; @(posedge clk); #1; guard++;
      end
      nz_valid = 1'b0;
      check_eq("nz_handshake", 32'(acc), 32'd1);
      if (!acc) break;
    end
    // Load is complete now: an extra offered entry must not be taken.
    nz_valid = 1'b1; nz_val = 8'h55; nz_last = 1'b0;
    repeat (2) begin
      @(negedge clk); check_eq("nz_ready_after_load", 32'(nz_ready), 32'd0);
      @(posedge clk); #1;
    end
    nz_valid = 1'b0;
  endtask

  // Monitor: checks every stream word; optionally pulses start mid-stream or resets mid-stream.
  task automatic monitor(input int abort_at, input int poke_at);
    int guard;
    int idx;
    logic [12:0] e;
    aborted = 0;
    @(negedge clk);
    check_eq("busy_after_start", 32'(busy), 32'd1);
    check_eq("errs_cleared_on_start", {err_zero, err_ovf}, 32'd0);
    guard = 0;
    while (val_out == '0 && guard < 3000) begin @(negedge clk); guard++; end
    check_eq("stream_started", 32'(guard < 3000), 32'd1);
    if (guard >= 3000) begin exp_q.delete(); return; end
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq($sformatf("stream[%0d]", idx), {done, ipv_out, col_out, val_out}, 32'(e));
      check_eq("busy_in_stream", 32'(busy), 32'd1);
      if (idx == abort_at) begin
        rst_n = 1'b0; #1;
        check_eq("abort_lanes", {done, ipv_out, col_out, val_out}, 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_errs", {err_zero, err_ovf}, 32'd0);
        exp_q.delete();
        aborted = 1;
        @(negedge clk); rst_n = 1'b1;
        break;
      end
      if (idx == poke_at) begin start = 1'b1; rows_in = 8'd3; cols_in = 8'd1; end
      if (idx == poke_at + 1) start = 1'b0;
      idx++;
      if (exp_q.size() > 0) @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_job(input logic [7:0] r, input logic [7:0] c, input int vdelay,
                         input int vgap, input int ngap, input int abort_at, input int poke_at);
    build_model(r, c);
    do_start(r, c);
    fork
      drive_vec(int'(c), vdelay, vgap);
      drive_nz(m_acc, ngap);
      monitor(abort_at, poke_at);
    join
    @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_lanes", {done, ipv_out, col_out, val_out}, 32'd0);
    check_eq("err_zero", 32'(err_zero), aborted ? 32'd0 : 32'(m_ez));
    check_eq("err_ovf", 32'(err_ovf), aborted ? 32'd0 : 32'(m_eo));
    @(posedge clk); #1;
  endtask

  task automatic bad_start(input logic [7:0] r, input logic [7:0] c, input bit ovf_now);
    do_start(r, c);
    @(negedge clk);
    check_eq("bad_start_busy", 32'(busy), 32'd0);
    check_eq("bad_start_err_ovf", 32'(err_ovf), 32'(ovf_now));
    check_eq("bad_start_vec_ready", 32'(vec_ready), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_lanes", {done, ipv_out, col_out, val_out}, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_errs", {err_zero, err_ovf}, 32'd0);
    check_eq("rst_ready", {vec_ready, nz_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference job, no gaps
    set_t1(); run_job(8'd2, 8'd3, 0, 0, 0, -1, -1);
    // Same job, vector late and gappy, entries first
    set_t1(); run_job(8'd2, 8'd3, 6, 3, 0, -1, -1);
    // Zero-valued entry dropped
    set_t3(); run_job(8'd4, 8'd3, 0, 0, 1, -1, -1);
    // Overflow: 33 entries without last
    gen_job(4, 33, 0, 1'b0); run_job(8'd7, 8'd4, 0, 1, 0, -1, -1);
    // Rejected starts in IDLE leave err_ovf from the previous job untouched
    bad_start(8'd5, 8'd0, 1'b1);
    bad_start(8'd5, 8'd129, 1'b1);
    bad_start(8'd0, 8'd3, 1'b1);
    // Start during TX is ignored (err_zero must survive)
    set_t3(); run_job(8'd4, 8'd3, 0, 0, 0, -1, 4);
    // Reset during TX_VEC, then the reference job again
    set_t3(); run_job(8'd4, 8'd3, 0, 0, 0, 3, -1);
    set_t1(); run_job(8'd2, 8'd3, 0, 0, 0, -1, -1);
    // Boundaries: full vector, exactly NZ_DEPTH entries ending with last, all-zero entries
    gen_job(MAX_COLS, NZ_DEPTH, 0, 1'b1); run_job(8'd1, 8'(MAX_COLS), 0, 0, 0, -1, -1);
    gen_job(2, 3, 100, 1'b1); run_job(8'd255, 8'd2, 0, 0, 1, -1, -1);
    gen_job(5, 40, 20, 1'b0); run_job(8'd9, 8'd5, 0, 1, 1, -1, -1);
    // Random jobs
    for (int t = 0; t < 20; t++) begin
      int c;
      c = $urandom_range(1, 20);
      gen_job(c, $urandom_range(1, 10), 20, 1'b1);
      run_job(8'($urandom_range(1, 255)), 8'(c), $urandom_range(0, 4),
              $urandom_range(0, 3), $urandom_range(0, 3), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
